// File: rtl/pipe_pkg.sv
// Shared pipeline types for the decode-stage hazard scoreboard: the in-flight
// entry record, the zero-register constant and the forwarding-select encoding.
package pipe_pkg;

   typedef struct packed {
      logic       valid;
      logic [4:0] dest;
      logic       is_load;
   } sb_entry_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b11;

   // $0 is hardwired, so it never depends on an in-flight write.
   function automatic logic src_match(input logic [4:0] src,
                                      input logic       src_valid,
                                      input sb_entry_t  e);
      return src_valid && (src != REG_ZERO) && e.valid && (e.dest == src);
   endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-stage view of the scoreboard: the ID instruction description going in,
// hazard/forwarding/stall information and perf counters coming back.
interface hazard_scoreboard_if #(
   parameter int CNT_W = 32
);
   logic             id_valid;
   logic [4:0]       reg1_num;
   logic [4:0]       reg2_num;
   logic             is_reg1_valid;
   logic             is_reg2_valid;
   logic [4:0]       dest_reg_num;
   logic             reg_write;
   logic             mem_to_reg;
   logic             flush;
   logic             mem_stall;
   logic             halted;
   logic             has_reg1_hazard;
   logic             has_reg2_hazard;
   logic             stall_id;
   logic [1:0]       fwd1_sel;
   logic [1:0]       fwd2_sel;
   logic [CNT_W-1:0] stall_count;
   logic             halt_seen;

   modport master (
      output id_valid, reg1_num, reg2_num, is_reg1_valid, is_reg2_valid,
             dest_reg_num, reg_write, mem_to_reg, flush, mem_stall, halted,
      input  has_reg1_hazard, has_reg2_hazard, stall_id, fwd1_sel, fwd2_sel,
             stall_count, halt_seen
   );

   modport slave (
      input  id_valid, reg1_num, reg2_num, is_reg1_valid, is_reg2_valid,
             dest_reg_num, reg_write, mem_to_reg, flush, mem_stall, halted,
      output has_reg1_hazard, has_reg2_hazard, stall_id, fwd1_sel, fwd2_sel,
             stall_count, halt_seen
   );
endinterface

// File: rtl/sb_match.sv
// Compares one ID source register against every in-flight entry; reports any hit,
// a load-use hazard against the EX entry, and the youngest matching stage.
module sb_match
   import pipe_pkg::*;
#(
   parameter int DEPTH = 3
) (
   input  logic       id_valid,
   input  logic [4:0] src_num,
   input  logic       src_valid,
   input  sb_entry_t  entries [DEPTH],
   output logic       hit,
   output logic       hazard,
   output logic [1:0] fwd_sel
);

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      hit     = 1'b0;
      fwd_sel = FWD_RF;
      // Oldest to youngest, so the youngest match is the last one assigned.
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (src_match(src_num, src_valid, entries[i])) begin
            hit     = 1'b1;
            fwd_sel = 2'(i + 1);
         end
      end
      hazard = id_valid && src_match(src_num, src_valid, entries[0]) && entries[0].is_load;
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writes in EX/MEM/WB, flags load-use hazards, selects
// forwarding sources, drives the ID stall and counts stall cycles.
module hazard_scoreboard
   import pipe_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int CNT_W = 32
) (
   input logic              clk,
   input logic              rst_b,
   hazard_scoreboard_if.slave sb
);

   sb_entry_t        entries [DEPTH];
   logic             halt_seen_q;
   logic [CNT_W-1:0] stall_count_q;
   logic             hit1, hit2, haz1, haz2;
   logic [1:0]       sel1, sel2;
   logic             accept;
   logic             stall_id;

   sb_match #(.DEPTH(DEPTH)) u_match_rs (
      .id_valid (sb.id_valid),
      .src_num  (sb.reg1_num),
      .src_valid(sb.is_reg1_valid),
      .entries  (entries),
      .hit      (hit1),
      .hazard   (haz1),
      .fwd_sel  (sel1)
   );

   sb_match #(.DEPTH(DEPTH)) u_match_rt (
      .id_valid (sb.id_valid),
      .src_num  (sb.reg2_num),
      .src_valid(sb.is_reg2_valid),
      .entries  (entries),
      .hit      (hit2),
      .hazard   (haz2),
      .fwd_sel  (sel2)
   );

   // A stalled load-use reader must read the regfile select, not a stale stage.
   assign sb.fwd1_sel        = (hit1 && !haz1) ? sel1 : FWD_RF;
   assign sb.fwd2_sel        = (hit2 && !haz2) ? sel2 : FWD_RF;
   assign sb.has_reg1_hazard = haz1;
   assign sb.has_reg2_hazard = haz2;
   assign stall_id           = haz1 | haz2 | sb.mem_stall;
   assign sb.stall_id        = stall_id;
   assign sb.stall_count     = stall_count_q;
   assign sb.halt_seen       = halt_seen_q;

   assign accept = sb.id_valid && sb.reg_write && (sb.dest_reg_num != REG_ZERO) &&
                   !sb.flush && !haz1 && !haz2 && !halt_seen_q;

   // NOTE: the entry array is a handful of flops, so it is reset like any other state.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
         halt_seen_q   <= 1'b0;
         stall_count_q <= '0;
      end else begin
         // NOTE: non-blocking so every stage shifts from its pre-edge neighbour.
         if (!sb.mem_stall) begin
            for (int i = 1; i < DEPTH; i++) entries[i] <= entries[i-1];
            entries[0] <= accept ? '{valid: 1'b1, dest: sb.dest_reg_num, is_load: sb.mem_to_reg}
                                 : '0;
            if (sb.halted && sb.id_valid && !sb.flush) halt_seen_q <= 1'b1;
         end
         if (stall_id) stall_count_q <= stall_count_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard: load-use, forwarding ages, $0,
// cache freeze, flush and halt drain, each with hand-computed expectations.
module tb_hazard_scoreboard;

   logic clk = 1'b0;
   logic rst_b;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   hazard_scoreboard_if #(.CNT_W(32)) sb_if ();

   hazard_scoreboard #(.DEPTH(3), .CNT_W(32)) dut (
      .clk  (clk),
      .rst_b(rst_b),
      .sb   (sb_if.slave)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Describe the ID instruction; both sources are read whenever it is valid.
   task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] d, input logic rw, input logic ld);
      sb_if.id_valid      = v;
      sb_if.reg1_num      = r1;
      sb_if.reg2_num      = r2;
      sb_if.is_reg1_valid = v;
      sb_if.is_reg2_valid = v;
      sb_if.dest_reg_num  = d;
      sb_if.reg_write     = rw;
      sb_if.mem_to_reg    = ld;
      sb_if.flush         = 1'b0;
      sb_if.halted        = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      repeat (3) tick();
   endtask

   initial begin
      rst_b           = 1'b0;
      sb_if.mem_stall = 1'b0;
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      #12;
      check("rst_stall_count", sb_if.stall_count, 32'd0);
      check("rst_halt_seen", {31'd0, sb_if.halt_seen}, 32'd0);
      check("rst_stall_id", {31'd0, sb_if.stall_id}, 32'd0);
      @(negedge clk);
      rst_b = 1'b1;
      tick();

      // lw $5 ; add $6,$5,$7
      set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1);
      #1 check("lw_no_stall", {31'd0, sb_if.stall_id}, 32'd0);
      tick();
      set_id(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b0);
      #1;
      check("lu_haz1", {31'd0, sb_if.has_reg1_hazard}, 32'd1);
      check("lu_haz2", {31'd0, sb_if.has_reg2_hazard}, 32'd0);
      check("lu_stall", {31'd0, sb_if.stall_id}, 32'd1);
      check("lu_fwd1_gated", {30'd0, sb_if.fwd1_sel}, 32'd0);
      tick();
      check("lu_release_haz1", {31'd0, sb_if.has_reg1_hazard}, 32'd0);
      check("lu_release_fwd1", {30'd0, sb_if.fwd1_sel}, 32'd2);
      check("lu_release_stall", {31'd0, sb_if.stall_id}, 32'd0);
      check("lu_count", sb_if.stall_count, 32'd1);
      tick();
      drain();

      // add $3 ; sub $4,$1,$3 ; forwarding ages through EX, MEM, WB, gone
      set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 5'd1, 5'd3, 5'd4, 1'b1, 1'b0);
      #1;
      check("fwd_ex", {30'd0, sb_if.fwd2_sel}, 32'd1);
      check("fwd_rs_rf", {30'd0, sb_if.fwd1_sel}, 32'd0);
      check("fwd_no_stall", {31'd0, sb_if.stall_id}, 32'd0);
      tick();
      set_id(1'b1, 5'd4, 5'd3, 5'd0, 1'b0, 1'b0);
      #1;
      check("fwd_mem", {30'd0, sb_if.fwd2_sel}, 32'd2);
      check("fwd_sub_ex", {30'd0, sb_if.fwd1_sel}, 32'd1);
      tick();
      check("fwd_wb", {30'd0, sb_if.fwd2_sel}, 32'd3);
      check("fwd_sub_mem", {30'd0, sb_if.fwd1_sel}, 32'd2);
      tick();
      check("fwd_gone", {30'd0, sb_if.fwd2_sel}, 32'd0);
      check("fwd_sub_wb", {30'd0, sb_if.fwd1_sel}, 32'd3);
      drain();

      // two writers of $9 back to back: the younger one wins
      set_id(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0);
      tick();
      tick();
      set_id(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0);
      #1 check("fwd_youngest", {30'd0, sb_if.fwd1_sel}, 32'd1);
      drain();

      // load into $0 followed by a reader of $0
      set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      #1;
      check("r0_haz1", {31'd0, sb_if.has_reg1_hazard}, 32'd0);
      check("r0_haz2", {31'd0, sb_if.has_reg2_hazard}, 32'd0);
      check("r0_fwd1", {30'd0, sb_if.fwd1_sel}, 32'd0);
      check("r0_entry0_valid", {31'd0, dut.entries[0].valid}, 32'd0);
      drain();

      // lw $8 then a reader while the cache holds the pipeline for 4 cycles
      set_id(1'b1, 5'd1, 5'd0, 5'd8, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd8, 5'd0, 5'd9, 1'b1, 1'b0);
      sb_if.mem_stall = 1'b1;
      #1 check("ms_haz1", {31'd0, sb_if.has_reg1_hazard}, 32'd1);
      for (int k = 0; k < 4; k++) begin
         tick();
         check($sformatf("ms_frozen_haz1_%0d", k), {31'd0, sb_if.has_reg1_hazard}, 32'd1);
      end
      check("ms_count", sb_if.stall_count, 32'd5);
      sb_if.mem_stall = 1'b0;
      #1 check("ms_release_stall", {31'd0, sb_if.stall_id}, 32'd1);
      tick();
      check("ms_bubble_haz1", {31'd0, sb_if.has_reg1_hazard}, 32'd0);
      check("ms_bubble_fwd1", {30'd0, sb_if.fwd1_sel}, 32'd2);
      check("ms_bubble_count", sb_if.stall_count, 32'd6);
      tick();
      drain();

      // flushed writer is never inserted
      set_id(1'b1, 5'd1, 5'd2, 5'd10, 1'b1, 1'b0);
      sb_if.flush = 1'b1;
      tick();
      set_id(1'b1, 5'd10, 5'd0, 5'd0, 1'b0, 1'b0);
      #1 check("flush_fwd1", {30'd0, sb_if.fwd1_sel}, 32'd0);

      // flush and load-use hazard together
      set_id(1'b1, 5'd1, 5'd0, 5'd11, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd11, 5'd0, 5'd12, 1'b1, 1'b0);
      sb_if.flush = 1'b1;
      #1;
      check("flhz_haz1", {31'd0, sb_if.has_reg1_hazard}, 32'd1);
      check("flhz_stall", {31'd0, sb_if.stall_id}, 32'd1);
      tick();
      set_id(1'b1, 5'd11, 5'd12, 5'd0, 1'b0, 1'b0);
      #1;
      check("flhz_fwd1_mem", {30'd0, sb_if.fwd1_sel}, 32'd2);
      check("flhz_fwd2_none", {30'd0, sb_if.fwd2_sel}, 32'd0);
      check("flhz_count", sb_if.stall_count, 32'd7);
      drain();

      // add $13 ; halt ; add $12 (blocked) ; drain
      set_id(1'b1, 5'd1, 5'd2, 5'd13, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      sb_if.halted = 1'b1;
      tick();
      check("halt_seen_set", {31'd0, sb_if.halt_seen}, 32'd1);
      set_id(1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 5'd13, 5'd12, 5'd0, 1'b0, 1'b0);
      #1;
      check("halt_old_wb", {30'd0, sb_if.fwd1_sel}, 32'd3);
      check("halt_blocked", {30'd0, sb_if.fwd2_sel}, 32'd0);
      tick();
      check("halt_drained", {30'd0, sb_if.fwd1_sel}, 32'd0);
      check("halt_sticky", {31'd0, sb_if.halt_seen}, 32'd1);
      check("halt_count", sb_if.stall_count, 32'd7);

      // asynchronous reset mid-stream
      rst_b = 1'b0;
      #1;
      check("arst_halt_seen", {31'd0, sb_if.halt_seen}, 32'd0);
      check("arst_count", sb_if.stall_count, 32'd0);
      @(negedge clk);
      rst_b = 1'b1;
      tick();
      check("post_rst_halt_seen", {31'd0, sb_if.halt_seen}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
